gf180mcu_fd_sc_mcu7t5v0__pwr_seq: RTL and testbench

//  Sequencer for a switchable power domain built from the 7-track 5V0 cells.
//  - Drives a daisy-chained header-switch enable bus one stage at a time to limit in-rush current.
//  - Handles the retention save/restore pulses and the isolation enable.
//  - Sits between the always-on control logic and the switched-rail row, which also holds the fill and tap cells.
//  - Rails VDD/VSS are present only under USE_POWER_PINS, like every cell in the library.

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__pwr_seq_if.sv | 36 +++
 rtl/gf180mcu_fd_sc_mcu7t5v0__pwr_seq.sv | 178 +++++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__pwr_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwr_seq_if.sv
// Control/status bundle between the always-on controller and the power-switch
// sequencer. Optional TIMEOUT flag exists only when
// GF180MCU_FD_SC_MCU7T5V0__PWR_SEQ_TIMEOUT_EN is defined.
interface gf180mcu_fd_sc_mcu7t5v0__pwr_seq_if #(
  parameter int unsigned N_STAGES = 4
);
  logic                REQ_ON;
  logic                SW_ACK;
  logic [N_STAGES-1:0] SW_EN;
  logic                ISO_EN;
  logic                RET_SAVE;
  logic                RET_RESTORE;
  logic                PWR_GOOD;
  logic                BUSY;
`ifdef GF180MCU_FD_SC_MCU7T5V0__PWR_SEQ_TIMEOUT_EN
  logic                TIMEOUT;
`endif

  // sequencer side
  modport master (
    input  REQ_ON, SW_ACK,
    output SW_EN, ISO_EN, RET_SAVE, RET_RESTORE, PWR_GOOD, BUSY
`ifdef GF180MCU_FD_SC_MCU7T5V0__PWR_SEQ_TIMEOUT_EN
    , output TIMEOUT
`endif
  );

  // controller / switch-row side
  modport slave (
    output REQ_ON, SW_ACK,
    input  SW_EN, ISO_EN, RET_SAVE, RET_RESTORE, PWR_GOOD, BUSY
`ifdef GF180MCU_FD_SC_MCU7T5V0__PWR_SEQ_TIMEOUT_EN
    , input TIMEOUT
`endif
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwr_seq.sv
// Power-domain sequencer: staged header-switch ramp, retention save/restore
// pulses and isolation control. All outputs registered.
// Optional feature macro: GF180MCU_FD_SC_MCU7T5V0__PWR_SEQ_TIMEOUT_EN
// (SW_ACK wait limit with sticky TIMEOUT flag). Rails under USE_POWER_PINS.
module gf180mcu_fd_sc_mcu7t5v0__pwr_seq #(
  parameter int unsigned N_STAGES    = 4,
  parameter int unsigned STAGE_DLY   = 8,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 64
) (
`ifdef USE_POWER_PINS
  inout wire VDD,
  inout wire VSS,
`endif
  input logic CLK,
  input logic RST,
  gf180mcu_fd_sc_mcu7t5v0__pwr_seq_if.master bus
);

  localparam logic [3:0] S_OFF      = 4'd0;
  localparam logic [3:0] S_RAMP     = 4'd1;
  localparam logic [3:0] S_WAIT_ACK = 4'd2;
  localparam logic [3:0] S_RESTORE  = 4'd3;
  localparam logic [3:0] S_UNISO    = 4'd4;
  localparam logic [3:0] S_ON       = 4'd5;
  localparam logic [3:0] S_ISO      = 4'd6;
  localparam logic [3:0] S_SAVE     = 4'd7;
  localparam logic [3:0] S_DRAIN    = 4'd8;

  localparam logic [N_STAGES-1:0] LSB      = N_STAGES'(1);
  localparam logic [CNT_W-1:0]    DLY_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0]    TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  logic [3:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [N_STAGES-1:0] sw_en;
  logic [N_STAGES-1:0] sw_up;
  logic [N_STAGES-1:0] sw_dn;
  logic                iso_en;
  logic                ret_save;
  logic                ret_restore;
  logic                pwr_good;
  logic                busy;
`ifdef GF180MCU_FD_SC_MCU7T5V0__PWR_SEQ_TIMEOUT_EN
  logic                timeout;
  assign bus.TIMEOUT = timeout;
`endif

  assign bus.SW_EN       = sw_en;
  assign bus.ISO_EN      = iso_en;
  assign bus.RET_SAVE    = ret_save;
  assign bus.RET_RESTORE = ret_restore;
  assign bus.PWR_GOOD    = pwr_good;
  assign bus.BUSY        = busy;

  // next switch-enable pattern: one more stage on (LSB first) or one off (MSB first)
  always_comb begin
    sw_up = (sw_en << 1) | LSB;
    sw_dn = sw_en >> 1;
  end

  // sequencing FSM with stage/ack counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_OFF;
      cnt         <= '0;
      sw_en       <= '0;
      iso_en      <= 1'b1;
      ret_save    <= 1'b0;
      ret_restore <= 1'b0;
      pwr_good    <= 1'b0;
      busy        <= 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__PWR_SEQ_TIMEOUT_EN
      timeout     <= 1'b0;
`endif
    end else begin
      ret_save    <= 1'b0;
      ret_restore <= 1'b0;
      case (state)
        S_OFF: begin
          if (bus.REQ_ON) begin
            sw_en <= LSB;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= (N_STAGES == 1) ? S_WAIT_ACK : S_RAMP;
`ifdef GF180MCU_FD_SC_MCU7T5V0__PWR_SEQ_TIMEOUT_EN
            timeout <= 1'b0;
`endif
          end
        end
        S_RAMP: begin
          if (cnt == DLY_LAST) begin
            sw_en <= sw_up;
            cnt   <= '0;
            if (&sw_up) state <= S_WAIT_ACK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAIT_ACK: begin
          // counter saturates at the limit so it never wraps when waiting forever
          if (bus.SW_ACK) begin
            ret_restore <= 1'b1;
            cnt         <= '0;
            state       <= S_RESTORE;
          end else if (cnt != TO_LAST) begin
            cnt <= cnt + CNT_W'(1);
          end
`ifdef GF180MCU_FD_SC_MCU7T5V0__PWR_SEQ_TIMEOUT_EN
          else begin
            // give up: drain the switches without restore, isolation stays on
            timeout <= 1'b1;
            sw_en   <= sw_dn;
            cnt     <= '0;
            if (sw_dn == '0) begin
              state <= S_OFF;
              busy  <= 1'b0;
            end else begin
              state <= S_DRAIN;
            end
          end
`endif
        end
        S_RESTORE: begin
          iso_en <= 1'b0;
          state  <= S_UNISO;
        end
        S_UNISO: begin
          pwr_good <= 1'b1;
          busy     <= 1'b0;
          state    <= S_ON;
        end
        S_ON: begin
          if (!bus.REQ_ON) begin
            iso_en   <= 1'b1;
            pwr_good <= 1'b0;
            busy     <= 1'b1;
            state    <= S_ISO;
          end
        end
        S_ISO: begin
          ret_save <= 1'b1;
          state    <= S_SAVE;
        end
        S_SAVE: begin
          sw_en <= sw_dn;
          cnt   <= '0;
          if (sw_dn == '0) begin
            state <= S_OFF;
            busy  <= 1'b0;
          end else begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (cnt == DLY_LAST) begin
            sw_en <= sw_dn;
            cnt   <= '0;
            if (sw_dn == '0) begin
              state <= S_OFF;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= S_OFF;
          cnt    <= '0;
          sw_en  <= '0;
          iso_en <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__pwr_seq.sv
// Directed bench for the power sequencer (N_STAGES=4, STAGE_DLY=8, TIMEOUT_CYC=64).
module tb_gf180mcu_fd_sc_mcu7t5v0__pwr_seq;
  localparam int unsigned N = 4;

  logic CLK = 1'b0;
  logic RST;
  int   tests  = 0;
  int   failed = 0;

  gf180mcu_fd_sc_mcu7t5v0__pwr_seq_if #(.N_STAGES(N)) bus ();

`ifdef USE_POWER_PINS
  wire VDD = 1'b1;
  wire VSS = 1'b0;
`endif

  gf180mcu_fd_sc_mcu7t5v0__pwr_seq #(
    .N_STAGES(N), .STAGE_DLY(8), .CNT_W(8), .TIMEOUT_CYC(64)
  ) dut (
`ifdef USE_POWER_PINS
    .VDD(VDD), .VSS(VSS),
`endif
    .CLK(CLK), .RST(RST), .bus(bus.master)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned    cyc;
    logic           rst, req, ack;
    logic [N-1:0]   sw;
    logic [4:0]     fl;   // {ISO_EN, RET_SAVE, RET_RESTORE, PWR_GOOD, BUSY}
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int unsigned cyc, logic rst, logic req, logic ack,
                              logic [N-1:0] sw, logic [4:0] fl);
    vec_t v;
    v.cyc = cyc; v.rst = rst; v.req = req; v.ack = ack; v.sw = sw; v.fl = fl;
    tbl.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.SW_EN, bus.ISO_EN, bus.RET_SAVE, bus.RET_RESTORE, bus.PWR_GOOD, bus.BUSY});
  endfunction

  task automatic drive(logic rst, logic req, logic ack);
    @(negedge CLK);
    RST = rst; bus.REQ_ON = req; bus.SW_ACK = ack;
  endtask

  task automatic step(int unsigned n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // isolation must cover any unpowered stage; save/restore mutually exclusive
  always @(negedge CLK) begin
    if (RST === 1'b0 && !$isunknown(outs()))
      check("invariant",
            32'((!(&bus.SW_EN) && !bus.ISO_EN) || (bus.RET_SAVE && bus.RET_RESTORE)), 32'd0);
  end

  initial begin
    RST = 1'b1; bus.REQ_ON = 1'b0; bus.SW_ACK = 1'b0;

    // reset and idle
    add(3,  1, 0, 0, 4'b0000, 5'b10000);
    add(20, 0, 0, 0, 4'b0000, 5'b10000);
    // power-up, ack at E0+30
    add(1, 0, 1, 0, 4'b0001, 5'b10001);
    add(7, 0, 1, 0, 4'b0001, 5'b10001);
    add(1, 0, 1, 0, 4'b0011, 5'b10001);
    add(7, 0, 1, 0, 4'b0011, 5'b10001);
    add(1, 0, 1, 0, 4'b0111, 5'b10001);
    add(7, 0, 1, 0, 4'b0111, 5'b10001);
    add(1, 0, 1, 0, 4'b1111, 5'b10001);
    add(5, 0, 1, 0, 4'b1111, 5'b10001);
    add(1, 0, 1, 1, 4'b1111, 5'b10101);
    add(1, 0, 1, 0, 4'b1111, 5'b00001);
    add(1, 0, 1, 0, 4'b1111, 5'b00010);
    add(5, 0, 1, 0, 4'b1111, 5'b00010);
    // power-down
    add(1, 0, 0, 0, 4'b1111, 5'b10001);
    add(1, 0, 0, 0, 4'b1111, 5'b11001);
    add(1, 0, 0, 0, 4'b0111, 5'b10001);
    add(7, 0, 0, 0, 4'b0111, 5'b10001);
    add(1, 0, 0, 0, 4'b0011, 5'b10001);
    add(7, 0, 0, 0, 4'b0011, 5'b10001);
    add(1, 0, 0, 0, 4'b0001, 5'b10001);
    add(7, 0, 0, 0, 4'b0001, 5'b10001);
    add(1, 0, 0, 0, 4'b0000, 5'b10000);
    add(5, 0, 0, 0, 4'b0000, 5'b10000);
    // request dropped at E0+5: ramp completes, ON for one edge, then down
    add(1,  0, 1, 0, 4'b0001, 5'b10001);
    add(4,  0, 1, 0, 4'b0001, 5'b10001);
    add(1,  0, 0, 0, 4'b0001, 5'b10001);
    add(18, 0, 0, 0, 4'b0111, 5'b10001);
    add(1,  0, 0, 0, 4'b1111, 5'b10001);
    add(1,  0, 0, 1, 4'b1111, 5'b10101);
    add(1,  0, 0, 0, 4'b1111, 5'b00001);
    add(1,  0, 0, 0, 4'b1111, 5'b00010);
    add(1,  0, 0, 0, 4'b1111, 5'b10001);
    add(1,  0, 0, 0, 4'b1111, 5'b11001);
    add(25, 0, 0, 0, 4'b0000, 5'b10000);
    // SW_ACK stuck high: full ramp still required
    add(1,  0, 1, 1, 4'b0001, 5'b10001);
    add(23, 0, 1, 1, 4'b0111, 5'b10001);
    add(1,  0, 1, 1, 4'b1111, 5'b10001);
    add(1,  0, 1, 1, 4'b1111, 5'b10101);
    add(1,  0, 1, 0, 4'b1111, 5'b00001);
    add(1,  0, 1, 0, 4'b1111, 5'b00010);
    // power-down with request bouncing back high mid-drain
    add(1,  0, 0, 0, 4'b1111, 5'b10001);
    add(5,  0, 1, 0, 4'b0111, 5'b10001);
    add(21, 0, 0, 0, 4'b0000, 5'b10000);
    add(5,  0, 0, 0, 4'b0000, 5'b10000);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].ack);
      step(tbl[i].cyc);
      check($sformatf("row%0d", i), outs(), 32'({tbl[i].sw, tbl[i].fl}));
    end

    // reset in the middle of a ramp
    drive(0, 1, 0);
    step(1);
    check("mid_rst_e0", outs(), 32'({4'b0001, 5'b10001}));
    step(12);
    check("mid_rst_e12", outs(), 32'({4'b0011, 5'b10001}));
    drive(1, 1, 0);
    step(1);
    check("mid_rst_clear", outs(), 32'({4'b0000, 5'b10000}));
    drive(0, 1, 0);
    step(1);
    check("mid_rst_restart", outs(), 32'({4'b0001, 5'b10001}));
    drive(1, 0, 0);
    step(2);
    check("mid_rst_idle", outs(), 32'({4'b0000, 5'b10000}));

`ifdef GF180MCU_FD_SC_MCU7T5V0__PWR_SEQ_TIMEOUT_EN
    begin
      bit saw_restore;
      bit saw_uniso;
      int unsigned budget;
      saw_restore = 1'b0;
      saw_uniso   = 1'b0;
      drive(0, 1, 0);
      step(1);
      step(24);
      check("to_ramp_done", outs(), 32'({4'b1111, 5'b10001}));
      step(63);
      check("to_before", 32'(bus.TIMEOUT), 32'd0);
      step(1);
      check("to_flag", 32'(bus.TIMEOUT), 32'd1);
      check("to_iso", 32'({bus.ISO_EN, bus.RET_RESTORE, bus.BUSY}), 32'b101);
      drive(0, 0, 0);
      budget = 0;
      while (bus.SW_EN !== '0 && budget < 40) begin
        step(1);
        budget++;
        if (bus.RET_RESTORE) saw_restore = 1'b1;
        if (!bus.ISO_EN) saw_uniso = 1'b1;
      end
      check("to_drained", outs(), 32'({4'b0000, 5'b10000}));
      check("to_no_restore", 32'({saw_restore, saw_uniso}), 32'd0);
      check("to_sticky", 32'(bus.TIMEOUT), 32'd1);
      drive(0, 1, 0);
      step(1);
      check("to_clear_e0", 32'({bus.TIMEOUT, bus.SW_EN}), 32'({1'b0, 4'b0001}));
      drive(1, 0, 0);
      step(1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
